silife_access_sched: RTL and testbench

//  Sequences and arbitrates the single row port of the silife cell array. Two requesters share it:
//  the host command engine (UART row read / row write / step) and an internal auto-run timer

---
 rtl/silife_access_sched.sv | 188 ++++++++++++++++++
 tb/tb_silife_access_sched.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/silife_access_sched.sv
// silife_access_sched: owns the single row port of the silife cell array and
// arbitrates it between the host command engine and an internal auto-step timer.
// Each granted operation runs IDLE -> EXEC -> DONE. The life_* pulse is visible
// in EXEC, and host_ack is visible in DONE.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   host_req/op/row/wdata/lock    host request (level), opcode, row, write data, grid lock
//   host_ack, host_rdata          one-cycle completion pulse, last read data
//   run_en, step_overrun          auto-run enable, sticky dropped-tick flag
//   gen_count, busy               generations stepped (wraps), FSM not idle
//   life_row_sel/en/wr_en/wdata   drive the silife array
//   life_rdata                    row data from the silife array
module silife_access_sched #(
  parameter int unsigned ROW_W       = 5,
  parameter int unsigned COLS        = 8,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned STEP_PERIOD = 6750000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             host_req,
  input  logic [1:0]       host_op,
  input  logic [ROW_W-1:0] host_row,
  input  logic [COLS-1:0]  host_wdata,
  input  logic             host_lock,
  output logic             host_ack,
  output logic [COLS-1:0]  host_rdata,
  input  logic             run_en,
  output logic             step_overrun,
  output logic [15:0]      gen_count,
  output logic             busy,
  output logic [ROW_W-1:0] life_row_sel,
  output logic             life_en,
  output logic             life_wr_en,
  output logic [COLS-1:0]  life_wdata,
  input  logic [COLS-1:0]  life_rdata
);

  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(STEP_PERIOD - 1);
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               grant_auto_q, grant_auto_d;
  logic [1:0]         op_q, op_d;
  logic               last_auto_q, last_auto_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic               pend_q, pend_d;

  logic               host_ack_d;
  logic [COLS-1:0]    host_rdata_d;
  logic               step_overrun_d;
  logic [15:0]        gen_count_d;
  logic               busy_d;
  logic [ROW_W-1:0]   life_row_sel_d;
  logic               life_en_d;
  logic               life_wr_en_d;
  logic [COLS-1:0]    life_wdata_d;

  logic               host_cand, auto_cand, pick_auto, tick;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_auto_q <= 1'b0;
      op_q         <= 2'b00;
      last_auto_q  <= 1'b0;
      timer_q      <= '0;
      pend_q       <= 1'b0;
      host_ack     <= 1'b0;
      host_rdata   <= '0;
      step_overrun <= 1'b0;
      gen_count    <= 16'h0000;
      busy         <= 1'b0;
      life_row_sel <= '0;
      life_en      <= 1'b0;
      life_wr_en   <= 1'b0;
      life_wdata   <= '0;
    end else begin
      state_q      <= state_d;
      grant_auto_q <= grant_auto_d;
      op_q         <= op_d;
      last_auto_q  <= last_auto_d;
      timer_q      <= timer_d;
      pend_q       <= pend_d;
      host_ack     <= host_ack_d;
      host_rdata   <= host_rdata_d;
      step_overrun <= step_overrun_d;
      gen_count    <= gen_count_d;
      busy         <= busy_d;
      life_row_sel <= life_row_sel_d;
      life_en      <= life_en_d;
      life_wr_en   <= life_wr_en_d;
      life_wdata   <= life_wdata_d;
    end
  end

  // Next-state, arbitration, timer and output logic
  always_comb begin
    state_d        = state_q;
    grant_auto_d   = grant_auto_q;
    op_d           = op_q;
    last_auto_d    = last_auto_q;
    timer_d        = timer_q;
    pend_d         = pend_q;
    host_ack_d     = 1'b0;
    host_rdata_d   = host_rdata;
    step_overrun_d = step_overrun;
    gen_count_d    = gen_count;
    busy_d         = 1'b0;
    life_row_sel_d = life_row_sel;
    life_en_d      = 1'b0;
    life_wr_en_d   = 1'b0;
    life_wdata_d   = life_wdata;
    host_cand      = 1'b0;
    auto_cand      = 1'b0;
    pick_auto      = 1'b0;
    tick           = 1'b0;

    case (state_q)
      S_IDLE: begin
        host_cand = host_req;
        auto_cand = pend_q & ~host_lock;
        if (host_cand | auto_cand) begin
          // Round robin: when both are asking, grant whichever lost last time
          pick_auto    = auto_cand & (~host_cand | ~last_auto_q);
          state_d      = S_EXEC;
          grant_auto_d = pick_auto;
          last_auto_d  = pick_auto;
          if (pick_auto) begin
            op_d      = OP_STEP;
            life_en_d = 1'b1;
          end else begin
            op_d = host_op;
            case (host_op)
              OP_READ: begin
                life_row_sel_d = host_row;
                life_wdata_d   = host_wdata;
              end
              OP_WRITE: begin
                life_row_sel_d = host_row;
                life_wdata_d   = host_wdata;
                life_wr_en_d   = 1'b1;
              end
              OP_STEP: life_en_d = 1'b1;
              default: ;
            endcase
          end
        end
      end
      S_EXEC: begin
        if (op_q == OP_STEP) gen_count_d = gen_count + 16'd1;
        if (!grant_auto_q && op_q == OP_READ) host_rdata_d = life_rdata;
        if (grant_auto_q) pend_d = 1'b0;
        host_ack_d = ~grant_auto_q;
        state_d    = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Auto-step timer; at most one tick can be pending at a time
    if (!run_en) begin
      timer_d = '0;
      pend_d  = 1'b0;
    end else if (timer_q == TIMER_LAST) begin
      timer_d = '0;
      tick    = 1'b1;
    end else begin
      timer_d = timer_q + CNT_W'(1);
    end
    if (tick) begin
      if (pend_d) step_overrun_d = 1'b1;
      else        pend_d = 1'b1;
    end

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_silife_access_sched.sv
// Self-checking bench for silife_access_sched (STEP_PERIOD=4): directed vector
// table, hand-written multi-cycle sequences, and randomized traffic compared
// against a cycle-numbered reference model of the request/grant rules.
module tb_silife_access_sched;

  localparam int P = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       host_req;
  logic [1:0] host_op;
  logic [4:0] host_row;
  logic [7:0] host_wdata;
  logic       host_lock;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic       run_en;
  logic       step_overrun;
  logic [15:0] gen_count;
  logic       busy;
  logic [4:0] life_row_sel;
  logic       life_en;
  logic       life_wr_en;
  logic [7:0] life_wdata;
  logic [7:0] life_rdata;

  logic [7:0] mem [32];
  assign life_rdata = mem[life_row_sel];

  silife_access_sched #(
    .ROW_W(5), .COLS(8), .CNT_W(24), .STEP_PERIOD(P)
  ) dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_op(host_op), .host_row(host_row),
    .host_wdata(host_wdata), .host_lock(host_lock),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .run_en(run_en), .step_overrun(step_overrun), .gen_count(gen_count),
    .busy(busy), .life_row_sel(life_row_sel), .life_en(life_en),
    .life_wr_en(life_wr_en), .life_wdata(life_wdata), .life_rdata(life_rdata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    host_req = 1'b0; host_op = 2'b00; host_row = 5'd0; host_wdata = 8'h00;
    host_lock = 1'b0; run_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Directed host transaction: grant in cycle N, pulse checked in N+1, ack in N+2
  typedef struct {
    logic [1:0]  op;
    logic [4:0]  row;
    logic [7:0]  wd;
    logic [7:0]  memval;
    logic        exp_wr;
    logic        exp_en;
    logic [4:0]  exp_row;
    logic [7:0]  exp_rdata;
    logic [15:0] exp_gen;
    logic        chk_wd;
  } vec_t;

  task automatic run_vec(input vec_t v);
    if (v.op == 2'b00) mem[v.row] = v.memval;
    host_req = 1'b1; host_op = v.op; host_row = v.row; host_wdata = v.wd;
    @(negedge clk);
    chk("vec_wr_pulse", 32'(life_wr_en), 32'(v.exp_wr));
    chk("vec_en_pulse", 32'(life_en), 32'(v.exp_en));
    chk("vec_row_sel", 32'(life_row_sel), 32'(v.exp_row));
    if (v.chk_wd) chk("vec_wdata", 32'(life_wdata), 32'(v.wd));
    chk("vec_ack_early", 32'(host_ack), 32'(0));
    chk("vec_busy", 32'(busy), 32'(1));
    // Changes after the grant must not matter
    host_op = ~v.op; host_row = ~v.row; host_wdata = ~v.wd;
    @(negedge clk);
    chk("vec_ack", 32'(host_ack), 32'(1));
    chk("vec_rdata", 32'(host_rdata), 32'(v.exp_rdata));
    chk("vec_gen", 32'(gen_count), 32'(v.exp_gen));
    chk("vec_pulse_gone", 32'({life_en, life_wr_en}), 32'(0));
    host_req = 1'b0;
    @(negedge clk);
    chk("vec_ack_drop", 32'(host_ack), 32'(0));
    chk("vec_idle", 32'(busy), 32'(0));
  endtask

  // Reference model, indexed by absolute cycle number since reset
  int          cyc, g, run_cnt;
  bit          g_auto, m_last_auto, m_pend, m_ovr;
  logic [1:0]  g_op;
  logic [4:0]  g_row, m_row;
  logic [7:0]  m_wdata, m_rdata;
  logic [15:0] m_gen;
  bit          e_en, e_wr, e_ack, e_busy;

  task automatic model_reset();
    cyc = 0; g = -1000; run_cnt = 0;
    g_auto = 0; m_last_auto = 0; m_pend = 0; m_ovr = 0;
    g_op = 2'b11; g_row = 5'd0; m_row = 5'd0; m_wdata = 8'h00; m_rdata = 8'h00;
    m_gen = 16'h0000;
    e_en = 0; e_wr = 0; e_ack = 0; e_busy = 0;
  endtask

  // Consumes the inputs of cycle cyc and produces expectations for cyc+1
  task automatic model_advance();
    bit tick, hc, ac, pick;
    if (cyc == g + 1) begin
      if (g_op == 2'b10) m_gen = m_gen + 16'd1;
      if (!g_auto && g_op == 2'b00) m_rdata = mem[g_row];
      if (g_auto) m_pend = 0;
    end
    if (cyc >= g + 3) begin
      hc = host_req;
      ac = m_pend && !host_lock;
      if (hc || ac) begin
        pick = ac && (!hc || !m_last_auto);
        g = cyc; g_auto = pick; m_last_auto = pick;
        g_op = pick ? 2'b10 : host_op;
        g_row = m_row;
        if (!pick && (host_op == 2'b00 || host_op == 2'b01)) begin
          m_row = host_row; m_wdata = host_wdata; g_row = host_row;
        end
      end
    end
    tick = 0;
    if (run_en) begin
      tick = (run_cnt % P) == P - 1;
      run_cnt++;
    end else begin
      run_cnt = 0;
      m_pend = 0;
    end
    if (tick) begin
      if (m_pend) m_ovr = 1;
      else m_pend = 1;
    end
    cyc++;
    e_en   = (cyc == g + 1) && (g_op == 2'b10);
    e_wr   = (cyc == g + 1) && (g_op == 2'b01);
    e_ack  = (cyc == g + 2) && !g_auto;
    e_busy = (cyc == g + 1) || (cyc == g + 2);
  endtask

  vec_t vecs[7];
  vec_t v6;
  int   np, acks, en_seen, wr_seen;
  logic [3:0] pat;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
    vecs[0] = '{2'b00, 5'd5,  8'h00, 8'hA5, 1'b0, 1'b0, 5'd5,  8'hA5, 16'd0, 1'b0};
    vecs[1] = '{2'b01, 5'd31, 8'h3C, 8'h00, 1'b1, 1'b0, 5'd31, 8'hA5, 16'd0, 1'b1};
    vecs[2] = '{2'b10, 5'd2,  8'h11, 8'h00, 1'b0, 1'b1, 5'd31, 8'hA5, 16'd1, 1'b0};
    vecs[3] = '{2'b11, 5'd7,  8'h22, 8'h00, 1'b0, 1'b0, 5'd31, 8'hA5, 16'd1, 1'b0};
    vecs[4] = '{2'b00, 5'd0,  8'h00, 8'h5A, 1'b0, 1'b0, 5'd0,  8'h5A, 16'd1, 1'b0};
    vecs[5] = '{2'b01, 5'd0,  8'hFF, 8'h00, 1'b1, 1'b0, 5'd0,  8'h5A, 16'd1, 1'b1};
    vecs[6] = '{2'b10, 5'd9,  8'h00, 8'h00, 1'b0, 1'b1, 5'd0,  8'h5A, 16'd2, 1'b0};

    // Reset state
    do_reset();
    chk("rst_ack", 32'(host_ack), 32'(0));
    chk("rst_rdata", 32'(host_rdata), 32'(0));
    chk("rst_overrun", 32'(step_overrun), 32'(0));
    chk("rst_gen", 32'(gen_count), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_row", 32'(life_row_sel), 32'(0));
    chk("rst_pulses", 32'({life_en, life_wr_en}), 32'(0));
    chk("rst_wdata", 32'(life_wdata), 32'(0));

    // Directed host transactions
    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Auto-run alone: one step every P cycles, no acks
    do_reset();
    run_en = 1'b1;
    np = 0; acks = 0; wr_seen = 0;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      if (life_en) begin
        chk("auto_gen_at_pulse", 32'(gen_count), 32'(np));
        chk("auto_pulse_cycle", 32'(k), 32'(5 + 4 * np));
        np++;
      end
      if (host_ack) acks++;
      if (life_wr_en) wr_seen++;
    end
    chk("auto_pulse_count", 32'(np), 32'(4));
    chk("auto_no_ack", 32'(acks), 32'(0));
    chk("auto_no_wr", 32'(wr_seen), 32'(0));

    // Host step and pending auto step competing: grants alternate
    do_reset();
    host_lock = 1'b1; run_en = 1'b1;
    repeat (5) @(negedge clk);
    host_lock = 1'b0; host_req = 1'b1; host_op = 2'b10;
    np = 0; acks = 0; pat = 4'b0000;
    for (int k = 0; k < 30 && acks < 2; k++) begin
      @(negedge clk);
      if (life_en) np++;
      if (host_ack) begin
        if (np >= 1 && np <= 4) pat[np-1] = 1'b1;
        acks++;
        if (acks == 2) host_req = 1'b0;
      end
    end
    chk("rr_acks", 32'(acks), 32'(2));
    chk("rr_steps", 32'(np), 32'(4));
    chk("rr_gen", 32'(gen_count), 32'(4));
    chk("rr_pattern", 32'(pat), 32'(4'b1010));

    // Lock defers auto steps; overrun flags dropped ticks; unlock grants one step
    do_reset();
    host_lock = 1'b1; run_en = 1'b1;
    en_seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (life_en) en_seen++;
    end
    chk("lock_no_step", 32'(en_seen), 32'(0));
    chk("lock_overrun", 32'(step_overrun), 32'(1));
    chk("lock_idle", 32'(busy), 32'(0));
    host_lock = 1'b0;
    en_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (life_en) en_seen++;
    end
    chk("unlock_one_step", 32'(en_seen), 32'(1));
    chk("unlock_gen", 32'(gen_count), 32'(1));

    // Reset during EXEC of a host write aborts it
    do_reset();
    v6 = '{2'b10, 5'd0, 8'h00, 8'h00, 1'b0, 1'b1, 5'd0, 8'h00, 16'd1, 1'b0};
    run_vec(v6);
    host_req = 1'b1; host_op = 2'b01; host_row = 5'd9; host_wdata = 8'h77;
    @(negedge clk);
    chk("abort_wr_pulse", 32'(life_wr_en), 32'(1));
    rst = 1'b1;
    #1;
    chk("abort_wr_cleared", 32'(life_wr_en), 32'(0));
    chk("abort_row", 32'(life_row_sel), 32'(0));
    chk("abort_wdata", 32'(life_wdata), 32'(0));
    chk("abort_gen", 32'(gen_count), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    host_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    acks = 0;
    repeat (3) begin
      @(negedge clk);
      if (host_ack) acks++;
    end
    chk("abort_no_ack", 32'(acks), 32'(0));
    v6 = '{2'b00, 5'd9, 8'h00, 8'h66, 1'b0, 1'b0, 5'd9, 8'h66, 16'd0, 1'b0};
    run_vec(v6);

    // Randomized traffic against the reference model
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    do_reset();
    model_reset();
    for (int i = 0; i < 500; i++) begin
      if (host_req && e_ack && ($urandom % 4 != 0)) host_req = 1'b0;
      else if (!host_req && ($urandom % 3 == 0)) begin
        host_req = 1'b1; host_op = 2'($urandom);
        host_row = 5'($urandom); host_wdata = 8'($urandom);
      end else if ($urandom % 8 == 0) begin
        host_op = 2'($urandom); host_row = 5'($urandom); host_wdata = 8'($urandom);
      end
      if ($urandom % 16 == 0) host_lock = ~host_lock;
      run_en = ($urandom % 16) != 0;
      model_advance();
      @(negedge clk);
      chk("rnd_ack", 32'(host_ack), 32'(e_ack));
      chk("rnd_en", 32'(life_en), 32'(e_en));
      chk("rnd_wr", 32'(life_wr_en), 32'(e_wr));
      chk("rnd_busy", 32'(busy), 32'(e_busy));
      chk("rnd_gen", 32'(gen_count), 32'(m_gen));
      chk("rnd_overrun", 32'(step_overrun), 32'(m_ovr));
      chk("rnd_rdata", 32'(host_rdata), 32'(m_rdata));
      chk("rnd_row", 32'(life_row_sel), 32'(m_row));
      chk("rnd_wdata", 32'(life_wdata), 32'(m_wdata));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
